// File: rtl/i2c_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_target : single-address open-drain I2C target with host byte port.  |
// | Optional SCL stretching: define I2C_TARGET_CLOCK_STRETCH_EN.            |
// | Revision   : 1.0                                                        |
// +--------------------------------------------------------------------------+
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        i2c_sda,
    inout  wire        i2c_scl,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack_en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_req,
    output logic       tx_underrun,
    output logic       addressed,
    output logic       rw,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_BYTE,
        S_RX_ACK, S_TX_BYTE, S_TX_ACK, S_WAIT_STOP
    } state_t;

    logic r_scl_meta, r_scl_sync, r_scl_prev;
    logic r_sda_meta, r_sda_sync, r_sda_prev;

    state_t     r_state, n_state;
    logic [2:0] r_bit_cnt, n_bit_cnt;
    logic [6:0] r_shift, n_shift;
    logic [6:0] r_tx_shift, n_tx_shift;
    logic [7:0] r_tx_buf, n_tx_buf;
    logic [7:0] r_rx_data, n_rx_data;
    logic       r_sda_oe, n_sda_oe;
    logic       r_ack_drv, n_ack_drv;
    logic       r_rx_acked, n_rx_acked;
    logic       r_tx_load, n_tx_load;
    logic       r_tx_got, n_tx_got;
    logic       r_rx_valid, n_rx_valid;
    logic       r_tx_req, n_tx_req;
    logic       r_underrun, n_underrun;
    logic       r_addressed, n_addressed;
    logic       r_rw, n_rw;
    logic       r_start_det, n_start_det;
    logic       r_stop_det, n_stop_det;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    logic       r_scl_oe, n_scl_oe;
    logic       r_stretch, n_stretch;
`endif

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic       w_tx_avail, w_load;
    logic [7:0] w_tx_byte;

    // Idle-high reset values keep the synchronizer from reporting a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_meta <= 1'b1; r_scl_sync <= 1'b1; r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1; r_sda_sync <= 1'b1; r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= i2c_scl;    r_scl_sync <= r_scl_meta; r_scl_prev <= r_scl_sync;
            r_sda_meta <= i2c_sda;    r_sda_sync <= r_sda_meta; r_sda_prev <= r_sda_sync;
        end
    end

    assign w_scl_rise = r_scl_sync & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_sync & r_scl_prev;
    assign w_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
    assign w_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;
    // A strobe arriving in the same clk as the byte is needed still counts.
    assign w_tx_avail = tx_valid | r_tx_got;
    assign w_tx_byte  = tx_valid ? tx_data : r_tx_buf;

    always_comb begin
        n_state     = r_state;
        n_bit_cnt   = r_bit_cnt;
        n_shift     = r_shift;
        n_tx_shift  = r_tx_shift;
        n_rx_data   = r_rx_data;
        n_sda_oe    = r_sda_oe;
        n_ack_drv   = r_ack_drv;
        n_rx_acked  = r_rx_acked;
        n_tx_load   = r_tx_load;
        n_underrun  = r_underrun;
        n_addressed = r_addressed;
        n_rw        = r_rw;
        n_rx_valid  = 1'b0;
        n_tx_req    = 1'b0;
        n_start_det = 1'b0;
        n_stop_det  = 1'b0;
        w_load      = 1'b0;
        n_tx_buf    = tx_valid ? tx_data : r_tx_buf;
        n_tx_got    = tx_valid | (r_tx_got & ~r_tx_req & ~r_rx_valid);
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
        n_scl_oe    = r_scl_oe;
        n_stretch   = r_stretch;
        // SCL is let go one clk after SDA has been set up.
        if (r_scl_oe && !r_stretch) n_scl_oe = 1'b0;
`endif

        case (r_state)
            S_IDLE: ;
            S_ADDR: begin
                if (w_scl_rise) begin
                    n_shift   = {r_shift[5:0], r_sda_sync};
                    n_bit_cnt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        if (r_shift == TARGET_ADDR) begin
                            n_rw      = r_sda_sync;
                            n_ack_drv = 1'b0;
                            n_state   = S_ADDR_ACK;
                        end else begin
                            n_state   = S_WAIT_STOP;
                        end
                    end
                end
            end
            S_ADDR_ACK: begin
                if (w_scl_fall) begin
                    if (!r_ack_drv) begin
                        n_sda_oe    = 1'b1;
                        n_addressed = 1'b1;
                        n_ack_drv   = 1'b1;
                        n_tx_req    = r_rw;
                    end else begin
                        n_ack_drv = 1'b0;
                        n_sda_oe  = 1'b0;
                        n_bit_cnt = 3'd0;
                        if (r_rw) begin
                            n_state = S_TX_BYTE;
                            w_load  = 1'b1;
                        end else begin
                            n_state = S_RX_BYTE;
                        end
                    end
                end
            end
            S_RX_BYTE: begin
                if (w_scl_rise) begin
                    n_shift   = {r_shift[5:0], r_sda_sync};
                    n_bit_cnt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        n_rx_data  = {r_shift, r_sda_sync};
                        n_rx_valid = 1'b1;
                        n_ack_drv  = 1'b0;
                        n_state    = S_RX_ACK;
                    end
                end
            end
            S_RX_ACK: begin
                if (w_scl_fall) begin
                    if (!r_ack_drv) begin
                        n_sda_oe   = rx_ack_en;
                        n_rx_acked = rx_ack_en;
                        n_ack_drv  = 1'b1;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
                        if (!w_tx_avail) begin
                            n_scl_oe  = 1'b1;
                            n_stretch = 1'b1;
                        end
`endif
                    end else begin
                        n_sda_oe  = 1'b0;
                        n_ack_drv = 1'b0;
                        n_bit_cnt = 3'd0;
                        n_state   = r_rx_acked ? S_RX_BYTE : S_WAIT_STOP;
                    end
                end
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
                if (r_stretch && w_tx_avail) begin
                    n_scl_oe  = 1'b0;
                    n_stretch = 1'b0;
                end
`endif
            end
            S_TX_BYTE: begin
                if (r_tx_load) begin
                    w_load = w_scl_fall;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
                    if (r_stretch) w_load = 1'b1;
`endif
                end else if (w_scl_fall) begin
                    if (r_bit_cnt == 3'd7) begin
                        n_sda_oe  = 1'b0;
                        n_bit_cnt = 3'd0;
                        n_state   = S_TX_ACK;
                    end else begin
                        n_sda_oe   = ~r_tx_shift[6];
                        n_tx_shift = {r_tx_shift[5:0], 1'b1};
                        n_bit_cnt  = r_bit_cnt + 3'd1;
                    end
                end
            end
            S_TX_ACK: begin
                if (w_scl_rise) begin
                    if (!r_sda_sync) begin
                        n_tx_req  = 1'b1;
                        n_tx_load = 1'b1;
                        n_bit_cnt = 3'd0;
                        n_state   = S_TX_BYTE;
                    end else begin
                        n_state = S_WAIT_STOP;
                    end
                end
            end
            S_WAIT_STOP: ;
            default: n_state = S_IDLE;
        endcase

        // Present bit 7 of the next read byte.
        if (w_load) begin
            if (w_tx_avail) begin
                n_tx_shift = w_tx_byte[6:0];
                n_sda_oe   = ~w_tx_byte[7];
                n_tx_load  = 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
                n_stretch  = 1'b0;
`endif
            end else begin
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
                n_sda_oe   = 1'b0;
                n_tx_load  = 1'b1;
                n_scl_oe   = 1'b1;
                n_stretch  = 1'b1;
`else
                n_tx_shift = 7'h7F;
                n_sda_oe   = 1'b0;
                n_tx_load  = 1'b0;
                n_underrun = 1'b1;
`endif
            end
        end

        if (w_start) begin
            n_state     = S_ADDR;
            n_bit_cnt   = 3'd0;
            n_addressed = 1'b0;
            n_underrun  = 1'b0;
            n_sda_oe    = 1'b0;
            n_ack_drv   = 1'b0;
            n_tx_load   = 1'b0;
            n_start_det = 1'b1;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
            n_scl_oe    = 1'b0;
            n_stretch   = 1'b0;
`endif
        end else if (w_stop) begin
            n_state     = S_IDLE;
            n_addressed = 1'b0;
            n_sda_oe    = 1'b0;
            n_tx_load   = 1'b0;
            n_stop_det  = 1'b1;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
            n_scl_oe    = 1'b0;
            n_stretch   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_tx_shift  <= 7'd0;
            r_tx_buf    <= 8'd0;
            r_rx_data   <= 8'd0;
            r_sda_oe    <= 1'b0;
            r_ack_drv   <= 1'b0;
            r_rx_acked  <= 1'b0;
            r_tx_load   <= 1'b0;
            r_tx_got    <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_tx_req    <= 1'b0;
            r_underrun  <= 1'b0;
            r_addressed <= 1'b0;
            r_rw        <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
            r_scl_oe    <= 1'b0;
            r_stretch   <= 1'b0;
`endif
        end else begin
            r_state     <= n_state;
            r_bit_cnt   <= n_bit_cnt;
            r_shift     <= n_shift;
            r_tx_shift  <= n_tx_shift;
            r_tx_buf    <= n_tx_buf;
            r_rx_data   <= n_rx_data;
            r_sda_oe    <= n_sda_oe;
            r_ack_drv   <= n_ack_drv;
            r_rx_acked  <= n_rx_acked;
            r_tx_load   <= n_tx_load;
            r_tx_got    <= n_tx_got;
            r_rx_valid  <= n_rx_valid;
            r_tx_req    <= n_tx_req;
            r_underrun  <= n_underrun;
            r_addressed <= n_addressed;
            r_rw        <= n_rw;
            r_start_det <= n_start_det;
            r_stop_det  <= n_stop_det;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
            r_scl_oe    <= n_scl_oe;
            r_stretch   <= n_stretch;
`endif
        end
    end

    assign i2c_sda = r_sda_oe ? 1'b0 : 1'bz;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    assign i2c_scl = r_scl_oe ? 1'b0 : 1'bz;
`endif

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_req      = r_tx_req;
    assign tx_underrun = r_underrun;
    assign addressed   = r_addressed;
    assign rw          = r_rw;
    assign start_det   = r_start_det;
    assign stop_det    = r_stop_det;

endmodule
`default_nettype wire

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- Single-address I2C target (slave) endpoint; the responder side of our I2C controller, used for loopback benches and for exposing FPGA registers to an external I2C master.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches the 7-bit address, ACKs, and moves bytes to and from a host-side byte interface.
- Open-drain: drives lines low only, otherwise releases to high-Z.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit address this target responds to.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i2c_sda  inout  1  bus data; driven 0 or high-Z.
- i2c_scl  inout  1  bus clock; driven 0 (stretch only) or high-Z.
- rx_data  out  8  last received data byte.
- rx_valid  out  1  one-clk pulse: rx_data updated.
- rx_ack_en  in  1  1 = ACK received data bytes, 0 = NACK them.
- tx_data  in  8  byte to return on a read.
- tx_valid  in  1  host strobe: tx_data loaded.
- tx_req  out  1  one-clk pulse: next read byte needed.
- tx_underrun  out  1  sticky; a read byte was sent without tx_valid. Cleared by START.
- addressed  out  1  high from address ACK until STOP/START.
- rw  out  1  R/W bit of the current transfer (1 = read).
- start_det  out  1  one-clk pulse per START or repeated START.
- stop_det  out  1  one-clk pulse per STOP.

Behaviour:
- Input conditioning: SCL/SDA pass a 2-FF synchronizer plus one history register. Edges are qualified on the synchronized pair.
- Bus conditions:
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - Data is sampled on SCL rise.
  - SDA drive changes only on the clk after SCL fall is detected (3 clk after the pin edge, serving as hold time).
- Reset values: all outputs 0, rx_data 8'h00, SDA/SCL released, state IDLE. Reset mid-transfer releases both lines within 1 clk and drops the transfer.
- States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
- START from any state:
  - Pulse start_det, clear bit counter, addressed, tx_underrun; release SDA; enter ADDR.
- STOP from any state:
  - Pulse stop_det, clear addressed, release SDA; enter IDLE.
- ADDR: shift 8 bits MSB first. After the 8th rise, compare bits[7:1] with TARGET_ADDR.
  - Match: latch rw, go ADDR_ACK.
  - Mismatch: go WAIT_STOP (SDA untouched).
- ADDR_ACK: on SCL fall, drive SDA low for one SCL period; set addressed.
  - rw=0: next fall releases SDA, go RX_BYTE.
  - rw=1: pulse tx_req at ACK start; on the next fall drive tx_data[7], go TX_BYTE.
- RX_BYTE: after the 8th rise, update rx_data and pulse rx_valid; go RX_ACK.
- RX_ACK: on the fall, drive SDA low if rx_ack_en=1, else release. Next fall releases SDA.
  - rx_ack_en=1: go RX_BYTE.
  - rx_ack_en=0: go WAIT_STOP.
- TX_BYTE: present bits 7..0 on successive falls (drive low for 0, release for 1).
  - Load source: the byte is loaded from tx_data if tx_valid arrived since tx_req.
  - Underrun: otherwise send 8'hFF and set tx_underrun.
  - After the 8th bit's fall, release SDA and go TX_ACK.
- TX_ACK: sample SDA on rise.
  - 0 (master ACK): pulse tx_req, go TX_BYTE.
  - 1 (NACK): go WAIT_STOP.
- WAIT_STOP: ignore SCL edges; exit only on START/STOP.
- Simultaneous tx_valid and tx_req in one clk: the tx_valid is accepted for the new byte.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary.

Optional Feature:
- Macro: I2C_TARGET_CLOCK_STRETCH_EN.
- Defined:
  - Read path: after tx_req, hold SCL low from the next SCL fall until tx_valid. Release SCL 1 clk after SDA is set up with bit 7.
  - Write path: after rx_valid, hold SCL low through the ACK low phase until the host asserts tx_valid (reused as rx consumed).
  - tx_underrun never sets.
- Undefined: SCL is never driven; i2c_scl is input-only and underrun behaviour applies.

Test Plan:
- Master writes addr 0x50 W, data 0xA5, 0x3C, STOP, rx_ack_en=1 -> ACK on all 3 bytes; rx_valid pulses twice with rx_data 0xA5 then 0x3C; addressed=1 then 0 on STOP; stop_det one pulse.
- Master reads 2 bytes from 0x50, host answers tx_req with 0x81 then 0x7E, master ACK then NACK -> SDA carries 0x81, 0x7E; tx_req pulses twice; tx_underrun=0; WAIT_STOP then IDLE.
- Master addresses 0x51 W, 1 byte -> SDA never driven by the target; no rx_valid; addressed stays 0.
- Write 0x50 W, 0x11, repeated START, read 0x50 R 1 byte -> start_det pulses twice; rw goes 0→1; tx_req pulses after the second address ACK.
- Assert reset while the target drives ACK low -> SDA released within 1 clk; all outputs 0. The next START+0x50 transfer completes normally.
- Read with tx_valid withheld:
  - Macro off -> byte 0xFF sent, tx_underrun=1.
  - Macro on -> SCL held low until tx_valid with 0x5A, then 0x5A sent.
